// File: rtl/otp_keystream_if.sv
// otp_keystream_if
//   Seed/control and key-delivery signals of the OTP keystream generator.
//   KEY_W and MAX_KEYS must match the generator instance that uses this bundle.
//   Signals:
//     load       seed-load request
//     seed       seed byte, sampled with load
//     mode       advance mode, sampled with load
//     key_ready  consumer accepts the presented key
//     key        current key
//     key_valid  key may be transferred
//     key_cnt    number of keys accepted since the last load
//     exhausted  all keys for this seed have been used
//   Modports: master = seed source / key consumer, slave = generator.
interface otp_keystream_if #(
    parameter int KEY_W    = 64,
    parameter int MAX_KEYS = 16
);
    localparam int CNT_W = $clog2(MAX_KEYS + 1);

    logic             load;
    logic [7:0]       seed;
    logic [1:0]       mode;
    logic             key_ready;
    logic [KEY_W-1:0] key;
    logic             key_valid;
    logic [CNT_W-1:0] key_cnt;
    logic             exhausted;

    modport master (
        output load, seed, mode, key_ready,
        input  key, key_valid, key_cnt, exhausted
    );

    modport slave (
        input  load, seed, mode, key_ready,
        output key, key_valid, key_cnt, exhausted
    );
endinterface

// File: rtl/otp_keystream.sv
// otp_keystream
//   One-time-pad key generator. A load builds the key from a seed byte
//   (byte i = seed ^ i) and latches the advance mode. Each accepted key
//   advances the key by a byte rotation (optionally mixed with the count)
//   until MAX_KEYS keys have been taken, after which a reseed is required.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    otp_keystream_if.slave (load/seed/mode/key_ready in,
//            key/key_valid/key_cnt/exhausted out)
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   IDLE      | no seed since reset; key is 0, key_ready ignored
//   RUN       | key presented with key_valid=1
//   EXHAUSTED | MAX_KEYS keys taken; everything held until load
module otp_keystream #(
    parameter int KEY_W       = 64,
    parameter int SHIFT_BYTES = 1,
    parameter int MAX_KEYS    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    otp_keystream_if.slave        bus
);
    localparam int CNT_W   = $clog2(MAX_KEYS + 1);
    localparam int N_BYTES = KEY_W / 8;
    localparam int R       = 8 * SHIFT_BYTES;

    if ((KEY_W % 8) != 0 || KEY_W < 16) begin : g_bad_key_w
        $error("otp_keystream: KEY_W must be a multiple of 8 and at least 16");
    end
    if (SHIFT_BYTES < 1 || SHIFT_BYTES > N_BYTES - 1) begin : g_bad_shift
        $error("otp_keystream: SHIFT_BYTES must be in 1..KEY_W/8-1");
    end
    if (MAX_KEYS < 1) begin : g_bad_max
        $error("otp_keystream: MAX_KEYS must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        EXHAUSTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             valid_q;
    logic             exh_q;

    logic [KEY_W-1:0] seed_pat;
    logic [KEY_W-1:0] rot_l;
    logic [KEY_W-1:0] rot_r;
    logic [31:0]      cnt_ext;
    logic [CNT_W-1:0] cnt_inc;
    logic             handshake;

    assign rot_l   = {key_q[KEY_W-R-1:0], key_q[KEY_W-1:KEY_W-R]};
    assign rot_r   = {key_q[R-1:0], key_q[KEY_W-1:R]};
    // Zero-extends the pre-increment count so its low byte is defined for any CNT_W.
    assign cnt_ext = 32'(cnt_q);
    assign cnt_inc = cnt_q + 1'b1;

    // Load wins over a coincident handshake, so a load cycle never advances.
    assign handshake = (state_q == RUN) && bus.key_ready && !bus.load;

    always_comb begin
        seed_pat = '0;
        for (int i = 0; i < N_BYTES; i++) begin
            seed_pat[8*i +: 8] = bus.seed ^ 8'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;

        if (bus.load) begin
            key_d   = seed_pat;
            // Reserved mode 3 is stored as 0 so the advance only sees 0..2.
            mode_d  = (bus.mode == 2'd3) ? 2'd0 : bus.mode;
            cnt_d   = '0;
            state_d = RUN;
        end else if (handshake) begin
            unique case (mode_q)
                2'd1:    key_d = rot_r;
                2'd2:    key_d = {rot_l[KEY_W-1:8], rot_l[7:0] ^ cnt_ext[7:0]};
                default: key_d = rot_l;
            endcase
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(MAX_KEYS)) begin
                state_d = EXHAUSTED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 2'd0;
            valid_q <= 1'b0;
            exh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            valid_q <= (state_d == RUN);
            exh_q   <= (state_d == EXHAUSTED);
        end
    end

    assign bus.key       = key_q;
    assign bus.key_valid = valid_q;
    assign bus.key_cnt   = cnt_q;
    assign bus.exhausted = exh_q;
endmodule

// File: tb/tb_otp_keystream.sv
module tb_otp_keystream;
    localparam int A_W   = 32;
    localparam int A_R   = 8;
    localparam int A_MAX = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    otp_keystream_if #(.KEY_W(32), .MAX_KEYS(4)) busa ();
    otp_keystream_if #(.KEY_W(64), .MAX_KEYS(4)) busb ();

    otp_keystream #(.KEY_W(32), .SHIFT_BYTES(1), .MAX_KEYS(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (busa)
    );

    otp_keystream #(.KEY_W(64), .SHIFT_BYTES(3), .MAX_KEYS(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (busb)
    );

    // Reference model for dut_a, expressed as plain integer arithmetic.
    longint unsigned m_key = 0;
    int              m_cnt = 0;
    int              m_mode = 0;
    bit              m_valid = 0;
    bit              m_exh = 0;

    function automatic longint unsigned pattern(input logic [7:0] s, input int nbytes);
        longint unsigned k = 0;
        for (int i = 0; i < nbytes; i++) begin
            k = k | (64'(s ^ 8'(i)) << (8 * i));
        end
        return k;
    endfunction

    function automatic longint unsigned mask_w(input int w);
        return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic longint unsigned rotl(input longint unsigned k, input int w, input int r);
        return ((k << r) | (k >> (w - r))) & mask_w(w);
    endfunction

    function automatic longint unsigned rotr(input longint unsigned k, input int w, input int r);
        return ((k >> r) | (k << (w - r))) & mask_w(w);
    endfunction

    // Advances one clock and updates the model from the inputs seen at that edge.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            m_key = 0; m_cnt = 0; m_mode = 0; m_valid = 0; m_exh = 0;
        end else if (busa.load) begin
            m_key   = pattern(busa.seed, A_W / 8);
            m_mode  = (busa.mode == 2'd3) ? 0 : int'(busa.mode);
            m_cnt   = 0;
            m_valid = 1;
            m_exh   = 0;
        end else if (m_valid && busa.key_ready) begin
            case (m_mode)
                1:       m_key = rotr(m_key, A_W, A_R);
                2:       m_key = rotl(m_key, A_W, A_R) ^ 64'(m_cnt & 8'hFF);
                default: m_key = rotl(m_key, A_W, A_R);
            endcase
            m_cnt = m_cnt + 1;
            if (m_cnt == A_MAX) begin
                m_valid = 0;
                m_exh   = 1;
            end
        end
        #1;
    endtask

    task automatic do_load(input logic [7:0] s, input logic [1:0] md);
        busa.load = 1'b1; busa.seed = s; busa.mode = md;
        step();
        busa.load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        busa.load = 1'b1; busa.seed = 8'hAA; busa.mode = 2'd1; busa.key_ready = 1'b1;
        step(); step();
        checks++;
        if (busa.key !== 32'h0 || busa.key_valid !== 1'b0 || busa.key_cnt !== 3'd0 || busa.exhausted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got key=%h v=%b cnt=%0d exh=%b exp key=0 v=0 cnt=0 exh=0",
                     busa.key, busa.key_valid, busa.key_cnt, busa.exhausted);
        end
        busa.load = 1'b0; busa.key_ready = 1'b0;
        reset = 1'b0;
        step(); step();
        checks++;
        if (busa.key !== 32'h0 || busa.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got key=%h v=%b exp key=0 v=0", busa.key, busa.key_valid);
        end
    endtask

    task automatic test_mode0();
        logic [31:0] exp_k [3] = '{32'h12111013, 32'h11101312, 32'h10131211};
        do_load(8'h10, 2'd0);
        checks++;
        if (busa.key !== 32'h13121110 || busa.key_valid !== 1'b1 || busa.key_cnt !== 3'd0) begin
            errors++;
            $display("FAIL load_mode0 got key=%h v=%b cnt=%0d exp key=13121110 v=1 cnt=0",
                     busa.key, busa.key_valid, busa.key_cnt);
        end
        busa.key_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (busa.key !== exp_k[i] || busa.key_cnt !== 3'(i + 1)) begin
                errors++;
                $display("FAIL mode0_hs%0d got key=%h cnt=%0d exp key=%h cnt=%0d",
                         i, busa.key, busa.key_cnt, exp_k[i], i + 1);
            end
        end
        busa.key_ready = 1'b0;
    endtask

    task automatic test_modes();
        do_load(8'h10, 2'd1);
        busa.key_ready = 1'b1;
        step();
        busa.key_ready = 1'b0;
        checks++;
        if (busa.key !== 32'h10131211) begin
            errors++;
            $display("FAIL mode1_rotr got key=%h exp key=10131211", busa.key);
        end
        do_load(8'h10, 2'd2);
        busa.key_ready = 1'b1;
        step();
        checks++;
        if (busa.key !== 32'h12111013) begin
            errors++;
            $display("FAIL mode2_hs0 got key=%h exp key=12111013", busa.key);
        end
        step();
        checks++;
        if (busa.key !== 32'h11101313) begin
            errors++;
            $display("FAIL mode2_hs1 got key=%h exp key=11101313", busa.key);
        end
        busa.key_ready = 1'b0;
    endtask

    task automatic test_exhaust();
        do_load(8'h10, 2'd0);
        busa.key_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (busa.key_valid !== 1'b0 || busa.exhausted !== 1'b1 || busa.key_cnt !== 3'd4 || busa.key !== 32'h13121110) begin
            errors++;
            $display("FAIL exhaust got v=%b exh=%b cnt=%0d key=%h exp v=0 exh=1 cnt=4 key=13121110",
                     busa.key_valid, busa.exhausted, busa.key_cnt, busa.key);
        end
        busa.key_ready = 1'b0;
        do_load(8'h22, 2'd0);
        checks++;
        if (busa.key_valid !== 1'b1 || busa.exhausted !== 1'b0 || busa.key_cnt !== 3'd0 || busa.key !== 32'h21202322) begin
            errors++;
            $display("FAIL reload_after_exhaust got v=%b exh=%b cnt=%0d key=%h exp v=1 exh=0 cnt=0 key=21202322",
                     busa.key_valid, busa.exhausted, busa.key_cnt, busa.key);
        end
    endtask

    task automatic test_load_priority();
        do_load(8'h5A, 2'd0);
        busa.key_ready = 1'b1;
        step(); step();
        busa.load = 1'b1; busa.seed = 8'h33; busa.mode = 2'd0;
        step();
        busa.load = 1'b0; busa.key_ready = 1'b0;
        checks++;
        if (busa.key !== 32'h30313233 || busa.key_cnt !== 3'd0 || busa.key_valid !== 1'b1) begin
            errors++;
            $display("FAIL load_priority got key=%h cnt=%0d v=%b exp key=30313233 cnt=0 v=1",
                     busa.key, busa.key_cnt, busa.key_valid);
        end
    endtask

    task automatic test_ready_toggle();
        logic [31:0] exp_k [4] = '{32'h12111013, 32'h12111013, 32'h11101312, 32'h11101312};
        logic [2:0]  exp_c [4] = '{3'd1, 3'd1, 3'd2, 3'd2};
        do_load(8'h10, 2'd0);
        for (int i = 0; i < 4; i++) begin
            busa.key_ready = (i % 2 == 0);
            busa.mode = 2'(i + 1);
            busa.seed = 8'(8'hC0 + i);
            step();
            checks++;
            if (busa.key !== exp_k[i] || busa.key_cnt !== exp_c[i]) begin
                errors++;
                $display("FAIL ready_toggle%0d got key=%h cnt=%0d exp key=%h cnt=%0d",
                         i, busa.key, busa.key_cnt, exp_k[i], exp_c[i]);
            end
        end
        busa.key_ready = 1'b0;
    endtask

    task automatic test_reset_with_load();
        do_load(8'h10, 2'd0);
        reset = 1'b1; busa.load = 1'b1; busa.seed = 8'h77;
        step();
        reset = 1'b0; busa.load = 1'b0;
        checks++;
        if (busa.key !== 32'h0 || busa.key_valid !== 1'b0 || busa.key_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_over_load got key=%h v=%b cnt=%0d exp key=0 v=0 cnt=0",
                     busa.key, busa.key_valid, busa.key_cnt);
        end
        busa.key_ready = 1'b1;
        step(); step(); step();
        busa.key_ready = 1'b0;
        checks++;
        if (busa.key !== 32'h0 || busa.key_valid !== 1'b0 || busa.exhausted !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores_ready got key=%h v=%b exh=%b exp key=0 v=0 exh=0",
                     busa.key, busa.key_valid, busa.exhausted);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(0, 63) == 0);
            busa.load      = ($urandom_range(0, 7) == 0);
            busa.seed      = 8'($urandom);
            busa.mode      = 2'($urandom_range(0, 3));
            busa.key_ready = ($urandom_range(0, 3) != 0);
            step();
            checks++;
            if (busa.key !== m_key[31:0] || busa.key_valid !== m_valid || busa.key_cnt !== 3'(m_cnt)
                || busa.exhausted !== m_exh) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random%0d got key=%h v=%b cnt=%0d exh=%b exp key=%h v=%b cnt=%0d exh=%b",
                             i, busa.key, busa.key_valid, busa.key_cnt, busa.exhausted,
                             m_key[31:0], m_valid, m_cnt, m_exh);
            end
        end
        reset = 1'b0; busa.load = 1'b0; busa.key_ready = 1'b0;
    endtask

    task automatic test_wide();
        busb.load = 1'b1; busb.seed = 8'h00; busb.mode = 2'd0; busb.key_ready = 1'b0;
        step();
        busb.load = 1'b0;
        checks++;
        if (busb.key !== 64'h0706050403020100 || busb.key_valid !== 1'b1) begin
            errors++;
            $display("FAIL wide_load got key=%h v=%b exp key=0706050403020100 v=1", busb.key, busb.key_valid);
        end
        busb.key_ready = 1'b1;
        step();
        busb.key_ready = 1'b0;
        checks++;
        if (busb.key !== 64'h0403020100070605 || busb.key_cnt !== 3'd1) begin
            errors++;
            $display("FAIL wide_rot24 got key=%h cnt=%0d exp key=0403020100070605 cnt=1", busb.key, busb.key_cnt);
        end
    endtask

    initial begin
        busa.load = 1'b0; busa.seed = 8'h0; busa.mode = 2'd0; busa.key_ready = 1'b0;
        busb.load = 1'b0; busb.seed = 8'h0; busb.mode = 2'd0; busb.key_ready = 1'b0;
        #2;
        test_reset();
        test_mode0();
        test_modes();
        test_exhaust();
        test_load_priority();
        test_ready_toggle();
        test_reset_with_load();
        test_random();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
